// File: rtl/tz_pkg.sv
// Shared types and helpers for the trapezoid frame-buffer writer.
// Covers the word addressing of the 256x256 1-bit frame buffer (32 pixels per word) and the queue entry format.
package tz_pkg;

    localparam int X_W    = 8;
    localparam int Y_W    = 8;
    localparam int WORD_W = 32;
    localparam int BIT_W  = 5;
    localparam int ADDR_W = Y_W + X_W - BIT_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] mask;
    } fb_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WRITE = 2'd3
    } fb_state_t;

    function automatic logic [ADDR_W-1:0] fb_word_addr(input logic [X_W-1:0] x,
                                                       input logic [Y_W-1:0] y);
        return {y, x[X_W-1:BIT_W]};
    endfunction

    function automatic logic [WORD_W-1:0] fb_bit_mask(input logic [X_W-1:0] x);
        return WORD_W'(1) << x[BIT_W-1:0];
    endfunction

endpackage

// File: rtl/tz_fb_fifo.sv
// Synchronous FIFO of frame-buffer mask entries.
// A push into a full queue is accepted only when a pop happens in the same cycle; otherwise it is dropped and flagged.
module tz_fb_fifo
    import tz_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      i_push,
    input  fb_entry_t i_data,
    input  logic      i_pop,
    output fb_entry_t o_head,
    output logic      o_full,
    output logic      o_empty,
    output logic      o_drop
);

    localparam int PTR_W = $clog2(DEPTH);

    fb_entry_t        r_mem [DEPTH];
    logic [PTR_W:0]   r_wptr;
    logic [PTR_W:0]   r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer bit tells full from empty when the indices match
    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                       (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_drop    = i_push && o_full && !w_do_pop;
    assign o_head    = r_mem[r_rptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[PTR_W-1:0]] <= i_data;
    end

endmodule

// File: rtl/tz_fb_writer.sv
// Frame-buffer writer: coalesces same-word pixels into masks, queues them,
// and ORs each mask into the SRAM by a serial read-modify-write.
module tz_fb_writer #(
    parameter int X_W     = 8,
    parameter int Y_W     = 8,
    parameter int WORD_W  = 32,
    parameter int Q_DEPTH = 8,
    parameter int CNT_W   = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              po,
    input  logic [X_W-1:0]    xo,
    input  logic [Y_W-1:0]    yo,
    input  logic              flush,
    output logic [10:0]       mem_addr,
    output logic              mem_ren,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              mem_wen,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              idle,
    output logic              ovf,
    output logic [CNT_W-1:0]  pix_cnt
);

    import tz_pkg::*;

    logic              r_acc_valid;
    logic [10:0]       r_acc_addr;
    logic [WORD_W-1:0] r_acc_mask;
    logic              r_flush_pend;
    logic              w_acc_valid_nxt;
    logic [10:0]       w_acc_addr_nxt;
    logic [WORD_W-1:0] w_acc_mask_nxt;
    logic              w_flush_serve;
    logic [10:0]       w_pix_addr;
    logic [WORD_W-1:0] w_pix_mask;
    logic              w_push;
    fb_entry_t         w_push_entry;

    fb_state_t         r_state;
    fb_state_t         w_state_nxt;
    fb_entry_t         w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_drop;
    logic              w_pop;

    logic [10:0]       r_mem_addr;
    logic              r_mem_ren;
    logic              r_mem_wen;
    logic [WORD_W-1:0] r_mem_wdata;
    logic              r_ovf;
    logic [CNT_W-1:0]  r_pix_cnt;

    assign w_pix_addr = fb_word_addr(xo, yo);
    assign w_pix_mask = fb_bit_mask(xo);

    // Pixel stream into the accumulator; a pending flush waits for a gap in po
    always_comb begin
        w_push          = 1'b0;
        w_push_entry    = '{addr: r_acc_addr, mask: r_acc_mask};
        w_acc_valid_nxt = r_acc_valid;
        w_acc_addr_nxt  = r_acc_addr;
        w_acc_mask_nxt  = r_acc_mask;
        w_flush_serve   = 1'b0;
        if (po) begin
            if (r_acc_valid && (r_acc_addr == w_pix_addr)) begin
                w_acc_mask_nxt = r_acc_mask | w_pix_mask;
            end else begin
                w_push          = r_acc_valid;
                w_acc_valid_nxt = 1'b1;
                w_acc_addr_nxt  = w_pix_addr;
                w_acc_mask_nxt  = w_pix_mask;
            end
        end else if (r_flush_pend) begin
            w_push          = r_acc_valid;
            w_acc_valid_nxt = 1'b0;
            w_flush_serve   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc_valid  <= 1'b0;
            r_flush_pend <= 1'b0;
        end else begin
            r_acc_valid  <= w_acc_valid_nxt;
            r_flush_pend <= flush || (r_flush_pend && !w_flush_serve);
        end
    end

    always_ff @(posedge clk) begin
        r_acc_addr <= w_acc_addr_nxt;
        r_acc_mask <= w_acc_mask_nxt;
    end

    tz_fb_fifo #(
        .DEPTH (Q_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

    // One queue entry at a time, so a word's write lands before any later read
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (!w_empty) w_state_nxt = ST_READ;
            ST_READ:  w_state_nxt = ST_WAIT;
            ST_WAIT:  w_state_nxt = ST_WRITE;
            ST_WRITE: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_pop = (r_state == ST_WRITE);

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Strobes are registered from the next state so they line up with READ/WRITE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_ren   <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_ren <= (w_state_nxt == ST_READ);
            r_mem_wen <= (w_state_nxt == ST_WRITE);
            if (w_state_nxt == ST_READ || w_state_nxt == ST_WRITE)
                r_mem_addr <= w_head.addr;
            if (w_state_nxt == ST_WRITE)
                r_mem_wdata <= mem_rdata | w_head.mask;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf     <= 1'b0;
            r_pix_cnt <= '0;
        end else begin
            if (w_drop) r_ovf <= 1'b1;
            if (po && (r_pix_cnt != {CNT_W{1'b1}}))
                r_pix_cnt <= r_pix_cnt + CNT_W'(1);
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_ren   = r_mem_ren;
    assign mem_wen   = r_mem_wen;
    assign mem_wdata = r_mem_wdata;
    assign ovf       = r_ovf;
    assign pix_cnt   = r_pix_cnt;
    assign idle      = !r_acc_valid && w_empty && (r_state == ST_IDLE) && !r_flush_pend;

endmodule

// File: tb/tb_tz_fb_writer.sv
// Directed bench for tz_fb_writer with a behavioural single-port SRAM and a write log.
module tb_tz_fb_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        po;
    logic [7:0]  xo;
    logic [7:0]  yo;
    logic        flush;
    logic [10:0] mem_addr;
    logic        mem_ren;
    logic [31:0] mem_rdata;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic        idle;
    logic        ovf;
    logic [19:0] pix_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] sram [2048];
    logic        pl_en = 1'b0;
    logic [10:0] pl_addr;
    logic [31:0] pl_data;
    logic [10:0] wr_addr [$];
    logic [31:0] wr_data [$];
    logic        both_seen = 1'b0;

    always #5 clk = ~clk;

    tz_fb_writer #(
        .X_W     (8),
        .Y_W     (8),
        .WORD_W  (32),
        .Q_DEPTH (8),
        .CNT_W   (20)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .po        (po),
        .xo        (xo),
        .yo        (yo),
        .flush     (flush),
        .mem_addr  (mem_addr),
        .mem_ren   (mem_ren),
        .mem_rdata (mem_rdata),
        .mem_wen   (mem_wen),
        .mem_wdata (mem_wdata),
        .idle      (idle),
        .ovf       (ovf),
        .pix_cnt   (pix_cnt)
    );

    // SRAM model: one-cycle read latency, write log for checking
    always @(posedge clk) begin
        if (pl_en) sram[pl_addr] <= pl_data;
        if (mem_ren) mem_rdata <= sram[mem_addr];
        if (mem_wen) begin
            sram[mem_addr] <= mem_wdata;
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
    end

    always @(negedge clk) begin
        if (mem_ren && mem_wen) both_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [10:0] a, input logic [31:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic pix(input logic [7:0] x, input logic [7:0] y, input logic fl);
        po    = 1'b1;
        xo    = x;
        yo    = y;
        flush = fl;
        tick();
        po    = 1'b0;
        flush = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (idle) break;
            tick();
        end
        check(tag, 32'(idle), 32'd1);
    endtask

    initial begin
        int n0;
        reset = 1'b1;
        po    = 1'b0;
        xo    = '0;
        yo    = '0;
        flush = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_ren",   32'(mem_ren),   32'd0);
        check("rst_wen",   32'(mem_wen),   32'd0);
        check("rst_addr",  32'(mem_addr),  32'd0);
        check("rst_wdata", mem_wdata,      32'd0);
        check("rst_ovf",   32'(ovf),       32'd0);
        check("rst_cnt",   32'(pix_cnt),   32'd0);
        check("rst_idle",  32'(idle),      32'd1);

        // Row run: x=0x20..0x3F at y=5 fills one whole word
        preload(11'h029, 32'h0);
        n0 = wr_addr.size();
        for (int x = 32; x < 64; x++) pix(8'(x), 8'd5, 1'b0);
        do_flush();
        wait_idle("row_idle");
        check("row_nwr",   32'(wr_addr.size() - n0), 32'd1);
        check("row_addr",  32'(wr_addr[n0]),         32'h029);
        check("row_wdata", wr_data[n0],              32'hFFFF_FFFF);
        check("row_cnt",   32'(pix_cnt),             32'd32);

        // Read-modify-write keeps existing bits
        preload(11'h029, 32'h0000_0001);
        n0 = wr_addr.size();
        pix(8'h22, 8'd5, 1'b0);
        do_flush();
        wait_idle("rmw_idle");
        check("rmw_nwr",   32'(wr_addr.size() - n0), 32'd1);
        check("rmw_addr",  32'(wr_addr[n0]),         32'h029);
        check("rmw_wdata", wr_data[n0],              32'h0000_0005);

        // Word split across x=0x1F/0x20
        preload(11'h000, 32'h0);
        preload(11'h001, 32'h0);
        n0 = wr_addr.size();
        pix(8'h1F, 8'd0, 1'b0);
        pix(8'h20, 8'd0, 1'b0);
        do_flush();
        wait_idle("split_idle");
        check("split_nwr",    32'(wr_addr.size() - n0), 32'd2);
        check("split_addr0",  32'(wr_addr[n0]),         32'h000);
        check("split_wdata0", wr_data[n0],              32'h8000_0000);
        check("split_addr1",  32'(wr_addr[n0+1]),       32'h001);
        check("split_wdata1", wr_data[n0+1],            32'h0000_0001);

        // Overflow: 12 one-pixel rows back to back
        for (int y = 0; y < 12; y++) preload(11'(y * 8), 32'h0);
        n0 = wr_addr.size();
        check("ovf_before", 32'(ovf), 32'd0);
        for (int y = 0; y < 12; y++) pix(8'h00, 8'(y), 1'b0);
        do_flush();
        wait_idle("ovf_idle");
        check("ovf_flag", 32'(ovf), 32'd1);
        check("ovf_nwr_ge9", 32'(wr_addr.size() - n0 >= 9), 32'd1);
        for (int k = 0; k < 9; k++) begin
            check($sformatf("ovf_addr%0d", k),  32'(wr_addr[n0+k]), 32'(k * 8));
            check($sformatf("ovf_wdata%0d", k), wr_data[n0+k],      32'h0000_0001);
        end

        // flush with po: pixel merged, flush served on the next gap
        preload(11'h010, 32'h0);
        n0 = wr_addr.size();
        pix(8'h03, 8'd2, 1'b0);
        pix(8'h04, 8'd2, 1'b1);
        check("fpo_pend_busy", 32'(idle), 32'd0);
        wait_idle("fpo_idle");
        check("fpo_nwr",   32'(wr_addr.size() - n0), 32'd1);
        check("fpo_addr",  32'(wr_addr[n0]),         32'h010);
        check("fpo_wdata", wr_data[n0],              32'h0000_0018);
        check("fpo_cnt",   32'(pix_cnt),             32'd49);

        // Reset during WAIT abandons the RMW
        n0 = wr_addr.size();
        pix(8'h40, 8'd9, 1'b0);
        do_flush();
        begin
            bit seen_ren = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (mem_ren) begin
                    seen_ren = 1'b1;
                    break;
                end
            end
            check("wrst_saw_read", 32'(seen_ren), 32'd1);
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("wrst_ren",   32'(mem_ren),  32'd0);
        check("wrst_wen",   32'(mem_wen),  32'd0);
        check("wrst_addr",  32'(mem_addr), 32'd0);
        check("wrst_wdata", mem_wdata,     32'd0);
        check("wrst_ovf",   32'(ovf),      32'd0);
        check("wrst_cnt",   32'(pix_cnt),  32'd0);
        check("wrst_idle",  32'(idle),     32'd1);
        for (int i = 0; i < 12; i++) tick();
        check("wrst_nwr",   32'(wr_addr.size() - n0), 32'd0);
        check("wrst_idle2", 32'(idle), 32'd1);

        check("ren_wen_excl", 32'(both_seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
